// File: rtl/dac_rx.sv
// dac_rx: left-justified serial audio receiver. Synchronizes bitck/lrck/dat
// into clk, assembles WIDTH-bit words, pairs left+right, and presents each
// pair through a one-deep valid/ready buffer with sticky length/overrun
// errors and a link-idle timeout.
module dac_rx #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dac_bitck,
    input  logic             dac_lrck,
    input  logic             dac_dat,
    output logic [WIDTH-1:0] out_left,
    output logic [WIDTH-1:0] out_right,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             len_err,
    output logic             overrun,
    output logic             idle,
    input  logic             err_clr
);
    localparam logic [5:0]  W_CNT  = 6'(WIDTH);
    localparam logic [15:0] TO_CNT = 16'(TIMEOUT);
    localparam logic [15:0] TO_M1  = 16'(TIMEOUT - 1);

    // Two-stage synchronizer pipe, each stage packed as {bitck, lrck, dat}
    logic [1:0][2:0] sync_pipe;
    logic            bitck_d;
    logic            edge_det, lrck_s, dat_s;

    // Word assembly / pairing state
    logic [15:0]      idle_cnt;
    logic             first_seen, prev_lrck, have_left;
    logic [5:0]       bit_cnt;
    logic [WIDTH-1:0] word, left_hold;
    logic [WIDTH-1:0] msb_mask, bit_mask;
    logic             boundary, len_short, pair_fire;

    assign lrck_s   = sync_pipe[1][1];
    assign dat_s    = sync_pipe[1][0];
    assign edge_det = sync_pipe[1][2] & ~bitck_d;

    // Bits land MSB-first at position WIDTH-1-count, so a short word is
    // left-aligned and zero-padded without any final shift.
    assign msb_mask  = {1'b1, {(WIDTH-1){1'b0}}};
    assign bit_mask  = msb_mask >> bit_cnt;
    assign idle      = (idle_cnt == TO_CNT);
    assign boundary  = edge_det & first_seen & (lrck_s != prev_lrck);
    assign len_short = boundary & (bit_cnt != 6'd0) & (bit_cnt < W_CNT);
    // A right word completes on a 1->0 boundary; it pairs only with a held left
    assign pair_fire = boundary & prev_lrck & have_left;

    // Synchronize the serial pins and keep the last bitck for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_pipe <= '0;
            bitck_d   <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[0], {dac_bitck, dac_lrck, dac_dat}};
            bitck_d   <= sync_pipe[1][2];
        end
    end

    // Word framing on bitck edges, left/right pairing, and idle timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt   <= '0;
            first_seen <= 1'b0;
            prev_lrck  <= 1'b0;
            have_left  <= 1'b0;
            bit_cnt    <= '0;
            word       <= '0;
            left_hold  <= '0;
        end else if (edge_det) begin
            idle_cnt   <= '0;
            first_seen <= 1'b1;
            prev_lrck  <= lrck_s;
            if (!first_seen || boundary) begin
                // Current bit is the MSB of a fresh word
                word    <= dat_s ? msb_mask : '0;
                bit_cnt <= 6'd1;
                if (boundary) begin
                    if (!prev_lrck) begin
                        left_hold <= word;
                        have_left <= 1'b1;
                    end else begin
                        // Right word either consumed by the pair or orphaned
                        have_left <= 1'b0;
                    end
                end
            end else begin
                if (bit_cnt < W_CNT && dat_s) word <= word | bit_mask;
                if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
            end
        end else begin
            if (idle_cnt != TO_CNT) idle_cnt <= idle_cnt + 16'd1;
            // Drop framing state as the counter reaches (or sits at) timeout
            if (idle_cnt >= TO_M1) begin
                bit_cnt    <= '0;
                have_left  <= 1'b0;
                first_seen <= 1'b0;
            end
        end
    end

    // One-deep output buffer and sticky errors (a set beats a same-cycle clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            out_left  <= '0;
            out_right <= '0;
            out_valid <= 1'b0;
            len_err   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (err_clr) begin
                len_err <= 1'b0;
                overrun <= 1'b0;
            end
            if (len_short) len_err <= 1'b1;
            if (pair_fire) begin
                if (!out_valid || out_ready) begin
                    out_left  <= left_hold;
                    out_right <= word;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
